rr_stream_mux: RTL
==================

// Module: rr_stream_mux
// PURPOSE
//  Parametrised N:1 streaming multiplexer with round-robin arbitration and a registered output stage.
//  Sequential successor to the combinational tree muxes: selection is made by an internal arbiter, not a select bus.
//  Merges N_CH valid/ready channels onto one output stream; each output word carries the index of its source channel.
//  Used wherever several producers share one downstream consumer.
// PARAMETERS
//  N_CH   8  number of input channels, >=2
//  WIDTH  8  data width per channel, in bits
//  SEL_W  localparam = $clog2(N_CH); width of the channel index
// PORTS
//  clk        in   1             clock, rising edge
//  rst        in   1             synchronous reset, active-high
//  in_data    in   N_CH*WIDTH    channel i occupies bits [i*WIDTH +: WIDTH]
//  in_valid   in   N_CH          per-channel valid
//  in_ready   out  N_CH          per-channel ready, at most one bit set
//  out_data   out  WIDTH         registered output data
//  out_sel    out  SEL_W         registered index of the source channel
//  out_valid  out  1             output register holds a word
//  out_ready  in   1             downstream accepts a word
//  in_last    in   N_CH          [RR_MUX_PKT_LOCK_EN only] per-channel end-of-packet
//  out_last   out  1             [RR_MUX_PKT_LOCK_EN only] registered in_last of the source channel
// BEHAVIOUR
//  - Reset: synchronous on rst=1 at the clk edge.
//    - out_valid=0, out_data=0, out_sel=0, out_last=0, rr_ptr=0, lock=0.
//    - in_ready=0 while rst=1.
//  - Output stage is one register with two states:
//    - EMPTY (out_valid=0) or FULL (out_valid=1).
//    - can_load = !out_valid | out_ready.
//  - Arbiter (combinational) scans in_valid starting at rr_ptr, ascending, wrapping N_CH-1 -> 0.
//    - The first set bit is the grant g.
//    - No in_valid set -> no grant.
//  - in_ready[g]=can_load; all other in_ready bits are 0.
//    - in_ready may depend on in_valid; upstream must not gate in_valid on in_ready.
//  - Transfer on in_valid[g] & in_ready[g]. At the next edge:
//    - out_data <= word g; out_sel <= g; out_valid <= 1; rr_ptr <= (g+1) mod N_CH.
//  - Input-to-output latency is 1 cycle.
//  - Full throughput: 1 word/cycle when out_ready is held at 1.
//  - FULL & out_ready & no grant -> out_valid <= 0 (becomes EMPTY).
//  - FULL & !out_ready -> all registers hold; all in_ready bits are 0.
//  - Simultaneous drain and load in one cycle is legal; no bubble is inserted.
//  - rr_ptr advances only on a transfer; idle cycles keep it unchanged.
//  - Fairness: with all channels valid and out_ready=1, grants go 0,1,..,N_CH-1,0,...
//  - rst mid-stream discards the held word; no handshake completes in the rst cycle.
//  - N_CH not a power of 2: the pointer wraps at N_CH-1, never reaching unused index codes.
// CONFIGURATION
//  - `RR_MUX_PKT_LOCK_EN defined:
//    - Adds in_last and out_last.
//    - A transfer with in_last[g]=0 sets lock=1 and holds the grant on g; rr_ptr is frozen.
//    - While locked, other channels get in_ready=0 even if g is idle.
//    - A transfer with in_last[g]=1 clears lock and sets rr_ptr=(g+1) mod N_CH.
//    - out_last <= in_last[g] on each transfer.
//  - Not defined:
//    - No in_last/out_last ports; arbitration is per word and there is no lock state.
// TESTING (N_CH=8, WIDTH=8)
//  1. Reset: rst=1 for 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, out_sel=0, in_ready=0.
//  2. Round robin: all in_valid=1, ch i data=0x10+i, out_ready=1 -> out_sel 0..7,0 on consecutive cycles;
//     out_data=0x10..0x17.
//  3. Backpressure: out_ready=0 for 3 cycles while FULL -> out_data/out_sel stable, in_ready=0;
//     resumes with the next channel in order.
//  4. Sparse valid: only ch 2 and 6 valid, rr_ptr=3 -> grant ch6, then ch2, then ch6.
//  5. Mid-stream reset: rst=1 while FULL with out_ready=0 -> out_valid=0 next cycle; first grant after is ch0.
//  6. [RR_MUX_PKT_LOCK_EN] ch1 sends a 3-word packet (last on word 3) while ch0 and ch2 are valid ->
//     out_sel=1,1,1 with out_last=0,0,1, then ch2.

Source files
------------

// File: rtl/rr_stream_mux.sv
// rr_stream_mux: N_CH:1 valid/ready stream mux with round-robin arbitration and one registered output stage.
// Optional packet locking (in_last/out_last ports) is enabled by defining RR_MUX_PKT_LOCK_EN.
module rr_stream_mux #(
    parameter int unsigned N_CH  = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH*WIDTH-1:0]   in_data,
    input  logic [N_CH-1:0]         in_valid,
    output logic [N_CH-1:0]         in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [$clog2(N_CH)-1:0] out_sel,
    output logic                    out_valid,
    input  logic                    out_ready
`ifdef RR_MUX_PKT_LOCK_EN
    ,
    input  logic [N_CH-1:0]         in_last,
    output logic                    out_last
`endif
);

    localparam int unsigned SEL_W = $clog2(N_CH);
    localparam int unsigned PTR_W = SEL_W + 1;

    logic [WIDTH-1:0] word_a [N_CH];

    logic [SEL_W-1:0] rr_ptr_q,    rr_ptr_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SEL_W-1:0] out_sel_q,   out_sel_d;
    logic             out_valid_q, out_valid_d;
`ifdef RR_MUX_PKT_LOCK_EN
    logic             lock_q,      lock_d;
    logic             out_last_q,  out_last_d;
`endif

    logic             grant_vld_c;
    logic [SEL_W-1:0] grant_c;
    logic             can_load_c;
    logic             xfer_c;
    logic [SEL_W-1:0] ptr_next_c;

    for (genvar i = 0; i < N_CH; i++) begin : g_word
        assign word_a[i] = in_data[i*WIDTH +: WIDTH];
    end

    // Round-robin scan from rr_ptr upward; the sum is kept one bit wider so the wrap is exact for any N_CH.
    always_comb begin
        grant_vld_c = 1'b0;
        grant_c     = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            logic [PTR_W-1:0] cand;
            cand = {1'b0, rr_ptr_q} + PTR_W'(k);
            if (cand >= PTR_W'(N_CH)) begin
                cand = cand - PTR_W'(N_CH);
            end
            if (!grant_vld_c && in_valid[SEL_W'(cand)]) begin
                grant_vld_c = 1'b1;
                grant_c     = SEL_W'(cand);
            end
        end
`ifdef RR_MUX_PKT_LOCK_EN
        // Mid-packet the grant stays on the channel of the last transfer, even if it is idle.
        if (lock_q) begin
            grant_vld_c = in_valid[out_sel_q];
            grant_c     = out_sel_q;
        end
`endif
    end

    assign can_load_c = !out_valid_q || out_ready;
    assign xfer_c     = grant_vld_c && can_load_c && !rst;
    assign ptr_next_c = (grant_c == SEL_W'(N_CH - 1)) ? '0 : grant_c + SEL_W'(1);

    always_comb begin
        in_ready = '0;
        if (xfer_c) begin
            in_ready[grant_c] = 1'b1;
        end
    end

    // Next state of the output register and arbiter pointer.
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        out_valid_d = out_valid_q;
`ifdef RR_MUX_PKT_LOCK_EN
        lock_d      = lock_q;
        out_last_d  = out_last_q;
`endif
        if (xfer_c) begin
            out_data_d  = word_a[grant_c];
            out_sel_d   = grant_c;
            out_valid_d = 1'b1;
            rr_ptr_d    = ptr_next_c;
`ifdef RR_MUX_PKT_LOCK_EN
            out_last_d  = in_last[grant_c];
            lock_d      = !in_last[grant_c];
            if (!in_last[grant_c]) begin
                rr_ptr_d = rr_ptr_q;
            end
`endif
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
`ifdef RR_MUX_PKT_LOCK_EN
            lock_q      <= 1'b0;
            out_last_q  <= 1'b0;
`endif
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_valid_q <= out_valid_d;
`ifdef RR_MUX_PKT_LOCK_EN
            lock_q      <= lock_d;
            out_last_q  <= out_last_d;
`endif
        end
    end

    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_valid = out_valid_q;
`ifdef RR_MUX_PKT_LOCK_EN
    assign out_last  = out_last_q;
`endif

endmodule
